drum_seq_mul: RTL and testbench

- Sequential controller and datapath for a DRUM-k approximate multiplier.
- Per operand: leading-one detection by serial scan, truncation to a K-bit window, K-cycle shift-add multiply of the truncated values, final left shift.
- Valid/ready on input and output; one operation in flight.
- Used wherever a small-area, fixed-latency approximate multiplier is shared by a slow datapath.

---
 rtl/drum_seq_mul_if.sv | 27 ++
 rtl/drum_seq_mul.sv | 238 +++++++++++++++++++++++
 tb/tb_drum_seq_mul.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/drum_seq_mul_if.sv
// Handshake bundle for drum_seq_mul: operand request channel, result
// response channel and the busy status flag.
interface drum_seq_mul_if #(
  parameter int WIDTH = 16
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_p;
  logic                 out_approx;
  logic                 busy;

  // Requester side: drives operands and accepts results.
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, out_approx, busy
  );

  // Multiplier side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, out_approx, busy
  );
endinterface

// File: rtl/drum_seq_mul.sv
// drum_seq_mul: sequential DRUM-k approximate multiplier.
// Serial leading-one scan of both operands over bits [WIDTH-1:K]
// (WIDTH-K cycles), truncation of each operand to a K-bit window, K-cycle
// shift-add multiply of the windows, then one cycle to apply the combined
// left shift and present the result. Latency is WIDTH+1 edges after the
// accepting edge, independent of the data.
// Build option: define DRUM_UNBIAS_EN to force bit 0 of every truncated
// window to 1 (DRUM unbiasing). Undefined: plain truncation.
module drum_seq_mul #(
  parameter int WIDTH = 16,
  parameter int K     = 4
) (
  input  logic          clk,
  input  logic          rst,
  drum_seq_mul_if.slave bus
);

  localparam int IDXW = $clog2(WIDTH);
  localparam int SW   = IDXW + 1;
  localparam int CW   = $clog2(K + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOD  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_r;
  logic [WIDTH-1:0]     op_a_r;
  logic [WIDTH-1:0]     op_b_r;
  logic [IDXW-1:0]      idx_r;
  logic                 found_a_r;
  logic                 found_b_r;
  logic [IDXW-1:0]      pos_a_r;
  logic [IDXW-1:0]      pos_b_r;
  logic [IDXW-1:0]      sa_r;
  logic [IDXW-1:0]      sb_r;
  logic                 trunc_a_r;
  logic                 trunc_b_r;
  logic [2*K-1:0]       mcand_r;
  logic [K-1:0]         mplier_r;
  logic [2*K-1:0]       acc_r;
  logic [CW-1:0]        cnt_r;
  logic                 in_ready_r;
  logic                 busy_r;
  logic                 out_valid_r;
  logic [2*WIDTH-1:0]   out_p_r;
  logic                 out_approx_r;

  logic                 found_a_s;
  logic                 found_b_s;
  logic [IDXW-1:0]      pos_a_s;
  logic [IDXW-1:0]      pos_b_s;
  logic [IDXW-1:0]      sa_s;
  logic [IDXW-1:0]      sb_s;
  logic [K-1:0]         ta_s;
  logic [K-1:0]         tb_s;
  logic [SW-1:0]        shift_sum_s;
  logic [2*WIDTH-1:0]   acc_wide_s;

  // Shift amount that aligns the window's MSB with the leading one; zero
  // when no leading one was found above bit K-1.
  function automatic logic [IDXW-1:0] drum_shift(
    input logic            found,
    input logic [IDXW-1:0] pos
  );
    logic [IDXW-1:0] sh;
    if (found) begin
      sh = pos - IDXW'(K - 1);
    end else begin
      sh = {IDXW{1'b0}};
    end
    return sh;
  endfunction

  // K-bit window of x starting at bit sh, optionally unbiased when the
  // operand was actually truncated.
  function automatic logic [K-1:0] drum_window(
    input logic [WIDTH-1:0] x,
    input logic             found,
    input logic [IDXW-1:0]  sh
  );
    logic [WIDTH-1:0] y;
    logic [K-1:0]     t;
    y = x >> sh;
    t = K'(y);
`ifdef DRUM_UNBIAS_EN
    if (found) begin
      t[0] = 1'b1;
    end else begin
      t[0] = t[0];
    end
`else
    if (found) begin
      t = t;
    end else begin
      t = t;
    end
`endif
    return t;
  endfunction

  // Leading-one detection for the current scan bit, folded with the
  // already-latched result so the last LOD cycle sees its own bit.
  always_comb begin
    found_a_s = found_a_r;
    found_b_s = found_b_r;
    pos_a_s   = pos_a_r;
    pos_b_s   = pos_b_r;
    if (state_r == LOD) begin
      if (!found_a_r && op_a_r[idx_r]) begin
        found_a_s = 1'b1;
        pos_a_s   = idx_r;
      end else begin
        found_a_s = found_a_r;
        pos_a_s   = pos_a_r;
      end
      if (!found_b_r && op_b_r[idx_r]) begin
        found_b_s = 1'b1;
        pos_b_s   = idx_r;
      end else begin
        found_b_s = found_b_r;
        pos_b_s   = pos_b_r;
      end
    end else begin
      found_a_s = found_a_r;
      found_b_s = found_b_r;
    end
  end

  // Truncation windows and final shift amount.
  always_comb begin
    sa_s        = drum_shift(found_a_s, pos_a_s);
    sb_s        = drum_shift(found_b_s, pos_b_s);
    ta_s        = drum_window(op_a_r, found_a_s, sa_s);
    tb_s        = drum_window(op_b_r, found_b_s, sb_s);
    shift_sum_s = {1'b0, sa_r} + {1'b0, sb_r};
    acc_wide_s  = {{(2*WIDTH-2*K){1'b0}}, acc_r};
  end

  // Control FSM and datapath registers, including the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      op_a_r       <= {WIDTH{1'b0}};
      op_b_r       <= {WIDTH{1'b0}};
      idx_r        <= {IDXW{1'b0}};
      found_a_r    <= 1'b0;
      found_b_r    <= 1'b0;
      pos_a_r      <= {IDXW{1'b0}};
      pos_b_r      <= {IDXW{1'b0}};
      sa_r         <= {IDXW{1'b0}};
      sb_r         <= {IDXW{1'b0}};
      trunc_a_r    <= 1'b0;
      trunc_b_r    <= 1'b0;
      mcand_r      <= {(2*K){1'b0}};
      mplier_r     <= {K{1'b0}};
      acc_r        <= {(2*K){1'b0}};
      cnt_r        <= {CW{1'b0}};
      in_ready_r   <= 1'b1;
      busy_r       <= 1'b0;
      out_valid_r  <= 1'b0;
      out_p_r      <= {(2*WIDTH){1'b0}};
      out_approx_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            op_a_r     <= bus.in_a;
            op_b_r     <= bus.in_b;
            found_a_r  <= 1'b0;
            found_b_r  <= 1'b0;
            idx_r      <= IDXW'(WIDTH - 1);
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= LOD;
          end
        end
        LOD: begin
          found_a_r <= found_a_s;
          found_b_r <= found_b_s;
          pos_a_r   <= pos_a_s;
          pos_b_r   <= pos_b_s;
          idx_r     <= idx_r - IDXW'(1);
          // Last scanned bit is K; windows are frozen here.
          if (idx_r == IDXW'(K)) begin
            sa_r      <= sa_s;
            sb_r      <= sb_s;
            trunc_a_r <= found_a_s;
            trunc_b_r <= found_b_s;
            mcand_r   <= {{K{1'b0}}, ta_s};
            mplier_r  <= tb_s;
            acc_r     <= {(2*K){1'b0}};
            cnt_r     <= {CW{1'b0}};
            state_r   <= MUL;
          end
        end
        MUL: begin
          if (cnt_r != CW'(K)) begin
            if (mplier_r[0]) begin
              acc_r <= acc_r + mcand_r;
            end
            mcand_r  <= {mcand_r[2*K-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[K-1:1]};
            cnt_r    <= cnt_r + CW'(1);
          end else begin
            out_p_r      <= acc_wide_s << shift_sum_s;
            out_approx_r <= trunc_a_r | trunc_b_r;
            out_valid_r  <= 1'b1;
            state_r      <= DONE;
          end
        end
        DONE: begin
          if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.busy       = busy_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_p      = out_p_r;
  assign bus.out_approx = out_approx_r;

endmodule

// File: tb/tb_drum_seq_mul.sv
// Self-checking bench for drum_seq_mul: directed operand sequence with a
// reference-model scoreboard, latency/hold/handshake checks and
// asynchronous reset aborts.
module tb_drum_seq_mul;

  localparam int WIDTH = 16;
  localparam int K     = 4;

  typedef struct packed {
    logic               approx;
    logic [2*WIDTH-1:0] p;
  } res_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  res_t exp_q[$];
  logic [2*WIDTH-1:0] last_p;
  logic               last_x;

  drum_seq_mul_if #(.WIDTH(WIDTH)) bus ();

  drum_seq_mul #(.WIDTH(WIDTH), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // DRUM reference for one operand: leading one via upward scan.
  function automatic void drum_operand(input logic [WIDTH-1:0] x,
                                       output longint t, output int s, output bit tr);
    int msb;
    msb = -1;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) msb = i;
    end
    if (msb >= K) begin
      s  = msb - K + 1;
      t  = longint'(x >> s) & ((64'd1 << K) - 64'd1);
      tr = 1'b1;
`ifdef DRUM_UNBIAS_EN
      t  = t | 64'd1;
`endif
    end else begin
      s  = 0;
      t  = longint'(x);
      tr = 1'b0;
    end
  endfunction

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    longint ta, tb;
    int sa, sb;
    bit tra, trb;
    logic [63:0] prod;
    res_t r;
    drum_operand(a, ta, sa, tra);
    drum_operand(b, tb, sb, trb);
    prod     = 64'(ta * tb) << (sa + sb);
    r.p      = prod[2*WIDTH-1:0];
    r.approx = tra | trb;
    return r;
  endfunction

  // Wait for in_ready, present operands for one accepting edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    exp_q.push_back(model(a, b));
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = {WIDTH{1'b0}};
    bus.in_b     = {WIDTH{1'b0}};
  endtask

  // Wait for the result, check latency and value, optionally stall, then retire.
  task automatic collect(input string tag, input int hold);
    int   lat;
    res_t e;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.out_valid && lat < 100);
    chk({tag, "_latency"}, 64'(lat), 64'(WIDTH + 1));
    if (exp_q.size() == 0) begin
      e = '0;
      chk({tag, "_scoreboard_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
    end
    chk({tag, "_p"}, 64'(bus.out_p), 64'(e.p));
    chk({tag, "_approx"}, 64'(bus.out_approx), 64'(e.approx));
    last_p = bus.out_p;
    last_x = bus.out_approx;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 16'hAAAA;
      bus.in_b     = 16'h5555;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, "_hold_p"}, 64'(bus.out_p), 64'(e.p));
      chk({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_in_ready_back"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_vec         = 0;
    n_bad         = 0;
    last_p        = '0;
    last_x        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = {WIDTH{1'b0}};
    bus.in_b      = {WIDTH{1'b0}};
    bus.out_ready = 1'b0;
    rst           = 1'b0;
    #1 rst = 1'b1;
    #20;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_p", 64'(bus.out_p), 64'd0);
    chk("rst_out_approx", 64'(bus.out_approx), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Exact small product.
    issue(16'd13, 16'd11);
    collect("m13x11", 0);
    chk("m13x11_const", 64'(last_p), 64'd143);
    chk("m13x11_exact", 64'(last_x), 64'd0);

    // Both operands truncated, build-dependent value.
    issue(16'h1234, 16'h0100);
    collect("m1234x0100", 0);
`ifdef DRUM_UNBIAS_EN
    chk("m1234x0100_const", 64'(last_p), 64'h144000);
`else
    chk("m1234x0100_const", 64'(last_p), 64'h120000);
`endif
    chk("m1234x0100_approx", 64'(last_x), 64'd1);

    // Maximum operands.
    issue(16'hFFFF, 16'hFFFF);
    collect("mffff", 0);
    chk("mffff_const", 64'(last_p), 64'hE1000000);

    // Zero operand.
    issue(16'h0000, 16'hFFFF);
    collect("mzero", 0);
    chk("mzero_const", 64'(last_p), 64'd0);
    chk("mzero_approx", 64'(last_x), 64'd1);

    issue(16'h00FF, 16'd3);
    collect("m00ffx3", 0);
    chk("m00ffx3_const", 64'(last_p), 64'd720);

    // Stalled consumer with ignored in_valid, then a back-to-back op.
    issue(16'h00F3, 16'h0021);
    collect("mhold", 5);
    issue(16'h8001, 16'h7FFF);
    collect("mafter_hold", 0);

    // Boundary window positions and a few random operands.
    issue(16'h0010, 16'h000F);
    collect("mbound_k", 0);
    for (int i = 0; i < 4; i++) begin
      issue(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      collect("mrand", 0);
    end

    // Reset during MUL aborts asynchronously.
    issue(16'h0ABC, 16'h0123);
    repeat (14) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mul_busy", 64'(bus.busy), 64'd0);
    chk("rst_mul_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_mul_out_valid", 64'(bus.out_valid), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Reset while a result is presented clears it asynchronously.
    issue(16'h1234, 16'h0100);
    repeat (WIDTH + 1) @(posedge clk);
    #1;
    chk("rst_done_valid_before", 64'(bus.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_done_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_done_out_p", 64'(bus.out_p), 64'd0);
    chk("rst_done_out_approx", 64'(bus.out_approx), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;

    issue(16'd13, 16'd11);
    collect("mpost_rst", 0);
    chk("mpost_rst_const", 64'(last_p), 64'd143);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
